mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/tron_mem_pkg.sv | 32 +++
 rtl/mem_port_arbiter_rr_arb2.sv | 30 +++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tron_mem_pkg.sv
// Shared constants and types for the two-requester memory port arbiter.
package tron_mem_pkg;

   // Arbiter FSM: free arbitration, or a locked burst owned by one requester.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BURST0 = 2'd1,
      ST_BURST1 = 2'd2
   } arb_state_e;

   // Default cap on consecutive locked grants while the other side waits.
   localparam int MAX_BURST_DEFAULT = 8;

   // Burst counter width; covers the full legal MAX_BURST range (1..255).
   localparam int BURST_CNT_W = 8;

   // Requester index constants, as stored in last_gnt.
   localparam logic REQ_IDX0 = 1'b0;
   localparam logic REQ_IDX1 = 1'b1;

   // Increment a burst count, holding it at the given ceiling.
   function automatic logic [BURST_CNT_W-1:0] sat_inc(
      input logic [BURST_CNT_W-1:0] cnt,
      input logic [BURST_CNT_W-1:0] ceiling
   );
      if (cnt >= ceiling) begin
         return ceiling;
      end
      return cnt + BURST_CNT_W'(1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side
// that was not granted last.
module rr_arb2
   import tron_mem_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_gnt,
   output logic gnt0,
   output logic gnt1
);

   // Purely combinational pick; exactly one grant whenever anyone requests.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (req0 && req1) begin
         if (last_gnt == REQ_IDX0) begin
            gnt1 = 1'b1;
         end else begin
            gnt0 = 1'b1;
         end
      end else if (req0) begin
         gnt0 = 1'b1;
      end else if (req1) begin
         gnt1 = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto a single memory port with round-robin
// fairness, locked bursts bounded by MAX_BURST, and read-return tagging.
module mem_port_arbiter
   import tron_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int MAX_BURST  = MAX_BURST_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  lock0,
   input  logic                  lock1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(MAX_BURST);

   arb_state_e             state_q, state_d;
   logic                   last_gnt_q, last_gnt_d;
   logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic                   rvalid0_q, rvalid1_q;

   logic                   rr_gnt0, rr_gnt1;
   logic                   gnt0_c, gnt1_c;
   logic                   owner_granted;
   logic                   owner_lock;
   logic                   other_req;
   logic [BURST_CNT_W-1:0] cnt_inc;
   logic                   sel;

   rr_arb2 u_rr_arb2 (
      .req0     (req0),
      .req1     (req1),
      .last_gnt (last_gnt_q),
      .gnt0     (rr_gnt0),
      .gnt1     (rr_gnt1)
   );

   // Grant: the burst owner keeps the port while it requests; otherwise the
   // round-robin pick decides. Nothing is granted while reset is held.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (!reset) begin
         if (state_q == ST_BURST0 && req0) begin
            gnt0_c = 1'b1;
         end else if (state_q == ST_BURST1 && req1) begin
            gnt1_c = 1'b1;
         end else begin
            gnt0_c = rr_gnt0;
            gnt1_c = rr_gnt1;
         end
      end
   end

   // Next state, burst counter and last-grant tracking.
   // The burst cap is checked against the count including the current grant,
   // so the owner receives exactly MAX_BURST grants before a waiting peer
   // gets the port on the following cycle.
   always_comb begin
      state_d       = state_q;
      burst_cnt_d   = burst_cnt_q;
      last_gnt_d    = last_gnt_q;
      owner_granted = 1'b0;
      owner_lock    = 1'b0;
      other_req     = 1'b0;
      cnt_inc       = sat_inc(burst_cnt_q, MAX_CNT);

      if (gnt0_c) begin
         last_gnt_d = REQ_IDX0;
      end else if (gnt1_c) begin
         last_gnt_d = REQ_IDX1;
      end

      if (state_q == ST_BURST0) begin
         owner_granted = gnt0_c;
         owner_lock    = lock0;
         other_req     = req1;
      end else if (state_q == ST_BURST1) begin
         owner_granted = gnt1_c;
         owner_lock    = lock1;
         other_req     = req0;
      end

      if (owner_granted) begin
         if (owner_lock && !(cnt_inc == MAX_CNT && other_req)) begin
            burst_cnt_d = cnt_inc;
         end else begin
            state_d     = ST_IDLE;
            burst_cnt_d = '0;
         end
      end else if (gnt0_c && lock0 && !(MAX_CNT == BURST_CNT_W'(1) && req1)) begin
         // A cap of one means the first grant already exhausts the burst.
         state_d     = ST_BURST0;
         burst_cnt_d = BURST_CNT_W'(1);
      end else if (gnt1_c && lock1 && !(MAX_CNT == BURST_CNT_W'(1) && req0)) begin
         state_d     = ST_BURST1;
         burst_cnt_d = BURST_CNT_W'(1);
      end else begin
         state_d     = ST_IDLE;
         burst_cnt_d = '0;
      end
   end

   // Memory port mux: granted requester, or last_gnt's fields when idle.
   always_comb begin
      sel       = last_gnt_q;
      if (gnt1_c) begin
         sel = REQ_IDX1;
      end else if (gnt0_c) begin
         sel = REQ_IDX0;
      end
      mem_addr  = (sel == REQ_IDX1) ? addr1  : addr0;
      mem_wdata = (sel == REQ_IDX1) ? wdata1 : wdata0;
      mem_we    = (gnt0_c & we0) | (gnt1_c & we1);
   end

   // State registers; read returns are tagged one cycle after a granted read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         last_gnt_q  <= REQ_IDX1;
         burst_cnt_q <= '0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         burst_cnt_q <= burst_cnt_d;
         rvalid0_q   <= gnt0_c & ~we0;
         rvalid1_q   <= gnt1_c & ~we1;
      end
   end

   assign gnt0    = gnt0_c;
   assign gnt1    = gnt1_c;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = mem_rdata;
   assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a small memory model.
module tb_mem_port_arbiter;
   import tron_mem_pkg::*;

   localparam int DW = 16;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, req1, lock0, lock1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
      .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: registered read, 1-cycle latency; contents loaded on the
   // first edge (during reset) as 0xA000|addr, with 0x1234 at address 0x10.
   logic [DW-1:0] mem [0:255];
   logic          mem_loaded = 1'b0;
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
         mem[8'h10] <= 16'h1234;
         mem_loaded <= 1'b1;
         mem_rdata  <= '0;
      end else begin
         if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
         mem_rdata <= mem[mem_addr[7:0]];
      end
   end

   typedef struct {
      logic          req0, req1, lock0, lock1, we0, we1;
      logic [AW-1:0] addr0, addr1;
      logic [DW-1:0] wdata0, wdata1;
      logic          egnt0, egnt1, ewe;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] ewdata;
      logic          erv0, erv1;
      logic [DW-1:0] erdata;
   } vec_t;

   vec_t vecs [12];

   function automatic vec_t mkv(
      input logic r0, input logic r1, input logic w0, input logic w1,
      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
      input logic g0, input logic g1, input logic ew,
      input logic [AW-1:0] ea, input logic [DW-1:0] ed,
      input logic rv0, input logic rv1, input logic [DW-1:0] rd);
      vec_t v;
      v.req0 = r0; v.req1 = r1; v.lock0 = 1'b0; v.lock1 = 1'b0;
      v.we0 = w0; v.we1 = w1; v.addr0 = a0; v.addr1 = a1;
      v.wdata0 = d0; v.wdata1 = d1;
      v.egnt0 = g0; v.egnt1 = g1; v.ewe = ew; v.eaddr = ea; v.ewdata = ed;
      v.erv0 = rv0; v.erv1 = rv1; v.erdata = rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic r1, input logic l0, input logic l1,
                        input logic w0, input logic w1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      req0 = r0; req1 = r1; lock0 = l0; lock1 = l1; we0 = w0; we1 = w1;
      addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic       starve_r0 [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic       starve_g1 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [7:0] starve_cnt[6] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd1};

   initial begin
      // Table: contention from reset, single read, IO write, read-back, mixed.
      vecs[0]  = mkv(1,1,0,0,16'h11,16'h21,0,0,        1,0,0,16'h11,0,      0,0,0);
      vecs[1]  = mkv(1,1,0,0,16'h11,16'h21,0,0,        0,1,0,16'h21,0,      1,0,16'hA011);
      vecs[2]  = mkv(1,1,0,0,16'h11,16'h21,0,0,        1,0,0,16'h11,0,      0,1,16'hA021);
      vecs[3]  = mkv(1,1,0,0,16'h11,16'h21,0,0,        0,1,0,16'h21,0,      1,0,16'hA011);
      vecs[4]  = mkv(1,0,0,0,16'h10,16'h21,0,0,        1,0,0,16'h10,0,      0,1,16'hA021);
      vecs[5]  = mkv(0,0,0,0,16'h10,16'h21,0,0,        0,0,0,16'h10,0,      1,0,16'h1234);
      vecs[6]  = mkv(0,1,0,1,16'h10,16'd127,0,16'h00A5, 0,1,1,16'd127,16'h00A5, 0,0,0);
      vecs[7]  = mkv(0,0,0,0,16'h10,16'd127,0,0,       0,0,0,16'd127,0,     0,0,0);
      vecs[8]  = mkv(1,0,0,0,16'd127,16'd127,0,0,      1,0,0,16'd127,0,     0,0,0);
      vecs[9]  = mkv(0,0,0,0,16'd127,16'd127,0,0,      0,0,0,16'd127,0,     1,0,16'h00A5);
      vecs[10] = mkv(1,1,1,0,16'h30,16'h21,16'h5555,0, 0,1,0,16'h21,0,      0,0,0);
      vecs[11] = mkv(1,1,1,0,16'h30,16'h21,16'h5555,0, 1,0,1,16'h30,16'h5555, 0,1,16'hA021);

      // Reset held with both requesting and a write pending.
      reset = 1'b1;
      drive(1, 1, 0, 0, 1, 1, 16'h11, 16'h21, 16'h0, 16'h0);
      tick(); tick();
      $display("reset: gnt=%b%b mem_we=%b rvalid=%b%b", gnt0, gnt1, mem_we, rvalid0, rvalid1);
      chk("reset_gnt0", 32'(gnt0), 0);
      chk("reset_gnt1", 32'(gnt1), 0);
      chk("reset_mem_we", 32'(mem_we), 0);
      chk("reset_rvalid0", 32'(rvalid0), 0);
      chk("reset_rvalid1", 32'(rvalid1), 0);
      chk("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
      chk("reset_last_gnt", 32'(dut.last_gnt_q), 1);
      chk("reset_burst_cnt", 32'(dut.burst_cnt_q), 0);
      reset = 1'b0;

      // Table-driven single-cycle vectors.
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].req0, vecs[i].req1, vecs[i].lock0, vecs[i].lock1,
               vecs[i].we0, vecs[i].we1, vecs[i].addr0, vecs[i].addr1,
               vecs[i].wdata0, vecs[i].wdata1);
         #3;
         $display("vec %0d: gnt=%b%b mem_we=%b mem_addr=%h rvalid=%b%b rdata=%h",
                  i, gnt0, gnt1, mem_we, mem_addr, rvalid0, rvalid1, rdata0);
         chk($sformatf("v%0d_gnt0", i), 32'(gnt0), 32'(vecs[i].egnt0));
         chk($sformatf("v%0d_gnt1", i), 32'(gnt1), 32'(vecs[i].egnt1));
         chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].ewe));
         chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].eaddr));
         if (vecs[i].ewe) chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].ewdata));
         chk($sformatf("v%0d_rvalid0", i), 32'(rvalid0), 32'(vecs[i].erv0));
         chk($sformatf("v%0d_rvalid1", i), 32'(rvalid1), 32'(vecs[i].erv1));
         if (vecs[i].erv0) chk($sformatf("v%0d_rdata0", i), 32'(rdata0), 32'(vecs[i].erdata));
         if (vecs[i].erv1) chk($sformatf("v%0d_rdata1", i), 32'(rdata1), 32'(vecs[i].erdata));
         tick();
      end

      // Starvation limit: locked requester 1 gets 4 grants, then 0 gets one.
      for (int i = 0; i < 6; i++) begin
         drive(starve_r0[i], 1, 0, 1, 1, 1, 16'h41, 16'h40, 16'h0, 16'h0);
         #3;
         $display("starve %0d: gnt=%b%b", i, gnt0, gnt1);
         chk($sformatf("starve%0d_gnt1", i), 32'(gnt1), 32'(starve_g1[i]));
         chk($sformatf("starve%0d_gnt0", i), 32'(gnt0), 32'(!starve_g1[i]));
         tick();
         chk($sformatf("starve%0d_cnt", i), 32'(dut.burst_cnt_q), 32'(starve_cnt[i]));
      end
      drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
      tick();
      chk("starve_exit_state", 32'(dut.state_q), 32'(ST_IDLE));

      // Uncontested locked burst: count saturates at 4 and the burst continues.
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, 0, 1, 0, 0, 16'h0, 16'h21, 16'h0, 16'h0);
         #3;
         $display("uncontested %0d: gnt=%b%b rvalid1=%b", i, gnt0, gnt1, rvalid1);
         chk($sformatf("unc%0d_gnt1", i), 32'(gnt1), 1);
         if (i > 0) begin
            chk($sformatf("unc%0d_rvalid1", i), 32'(rvalid1), 1);
            chk($sformatf("unc%0d_rdata1", i), 32'(rdata1), 32'h0000A021);
         end
         tick();
         chk($sformatf("unc%0d_cnt", i), 32'(dut.burst_cnt_q), (i >= 3) ? 4 : i + 1);
      end
      chk("unc_state", 32'(dut.state_q), 32'(ST_BURST1));
      drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
      tick();
      $display("uncontested release: state=%0d", dut.state_q);
      chk("unc_release_state", 32'(dut.state_q), 32'(ST_IDLE));
      chk("unc_release_rvalid1", 32'(rvalid1), 0);

      // Reset in cycle 2 of a locked read burst by requester 0.
      drive(1, 0, 1, 0, 0, 0, 16'h10, 16'h0, 16'h0, 16'h0);
      #3;
      chk("rst_burst_c1_gnt0", 32'(gnt0), 1);
      tick();
      chk("rst_burst_c2_rvalid0", 32'(rvalid0), 1);
      chk("rst_burst_c2_state", 32'(dut.state_q), 32'(ST_BURST0));
      reset = 1'b1;
      #1;
      $display("reset mid-burst: gnt0=%b rvalid0=%b mem_we=%b", gnt0, rvalid0, mem_we);
      chk("rst_burst_gnt0", 32'(gnt0), 0);
      chk("rst_burst_rvalid0", 32'(rvalid0), 0);
      chk("rst_burst_state", 32'(dut.state_q), 32'(ST_IDLE));
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 16'h10, 16'h0, 16'h0, 16'h0);
      #1;
      chk("rst_rel_rvalid0", 32'(rvalid0), 0);
      chk("rst_rel_cnt", 32'(dut.burst_cnt_q), 0);
      tick();
      chk("rst_rel2_rvalid0", 32'(rvalid0), 0);
      drive(1, 1, 0, 0, 0, 0, 16'h10, 16'h21, 16'h0, 16'h0);
      #3;
      $display("post-reset contention: gnt=%b%b", gnt0, gnt1);
      chk("rst_contend_gnt0", 32'(gnt0), 1);
      chk("rst_contend_gnt1", 32'(gnt1), 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
